ah_gnt_burst_hold: RTL and testbench

AH_GNT_BURST_HOLD -- requirements
Module: ah_gnt_burst_hold

---
 rtl/ah_arb_pkg.sv | 7 +
 rtl/ah_onehot_idx.sv | 18 +
 rtl/ah_gnt_burst_hold.sv | 83 ++++++++
 tb/tb_ah_gnt_burst_hold.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ah_arb_pkg.sv
// ah_arb_pkg: shared sizing and FSM state type for the grant burst-hold block
package ah_arb_pkg;
   localparam int N  = 4;
   localparam int LW = 4;
   localparam int IW = $clog2(N);
   typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;
endpackage

// File: rtl/ah_onehot_idx.sv
// ah_onehot_idx: lowest-set index of a grant vector with multi-hot and zero flags
module ah_onehot_idx #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          multi,
   output logic          zero
);
   // scan from the top so the lowest set bit is the last one written
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) idx = vec[i] ? IW'(i) : idx;
   end
   assign multi = |(vec & (vec - N'(1)));
   assign zero  = ~|vec;
endmodule

// File: rtl/ah_gnt_burst_hold.sv
// ah_gnt_burst_hold: holds an arbiter grant for a whole burst and reports LRU updates
module ah_gnt_burst_hold #(
   parameter int N   = ah_arb_pkg::N,
   parameter int LW  = ah_arb_pkg::LW,
   parameter int TMO = 64
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [N-1:0]              req,
   input  logic [N-1:0]              gnt,
   input  logic [N*LW-1:0]           req_len,
   output logic [N-1:0]              gnt_busy,
   output logic                      dn_valid,
   input  logic                      dn_ready,
   output logic [ah_arb_pkg::IW-1:0] dn_id,
   output logic                      dn_last,
   output logic                      upd_valid,
   output logic [ah_arb_pkg::IW-1:0] upd_id,
   output logic                      upd_abort,
   output logic                      gnt_err
);
   import ah_arb_pkg::*;
   state_t        state, nxt;
   logic [IW-1:0] owner, cap_idx;
   logic [LW-1:0] len, beat;
   logic [7:0]    stall;
   logic          cap_multi, cap_zero, fin, drop, tmo_hit;
   ah_onehot_idx #(.N(N), .IW(IW)) u_idx (
      .vec   (gnt),
      .idx   (cap_idx),
      .multi (cap_multi),
      .zero  (cap_zero)
   );
   assign fin     = state == BURST && dn_ready && beat == len;
   assign drop    = state == BURST && !req[owner];
   assign tmo_hit = state == BURST && !dn_ready && stall + 8'd1 == 8'(TMO);
   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt;
   end
   // next state: capture in IDLE, leave BURST on last beat, owner drop or stall timeout
   always_comb begin
      nxt = state == IDLE  ? (cap_zero ? IDLE : BURST) :
            state == BURST ? ((fin || drop || tmo_hit) ? RELEASE : BURST) : IDLE;
   end
   // owner capture, beat/stall counting and registered update fields
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         owner     <= '0;
         len       <= '0;
         beat      <= '0;
         stall     <= '0;
         upd_id    <= '0;
         upd_abort <= 1'b0;
         gnt_err   <= 1'b0;
      end else begin
         gnt_err <= state == IDLE && cap_multi;
         if (state == IDLE && !cap_zero) begin
            owner <= cap_idx;
            len   <= req_len[int'(cap_idx)*LW +: LW];
            beat  <= '0;
            stall <= '0;
         end
         if (state == BURST) begin
            beat  <= dn_ready ? ((&beat) ? beat : beat + LW'(1)) : beat;
            stall <= dn_ready ? 8'd0 : stall + 8'd1;
            if (nxt == RELEASE) begin
               upd_id    <= owner;
               upd_abort <= !fin;
            end
         end
      end
   end
   // outputs decoded from registered state
   always_comb begin
      gnt_busy  = {N{state != IDLE}};
      dn_valid  = state == BURST;
      dn_id     = owner;
      dn_last   = state == BURST && beat == len;
      upd_valid = state == RELEASE;
   end
endmodule

// File: tb/tb_ah_gnt_burst_hold.sv
// tb_ah_gnt_burst_hold: directed scoreboard bench for the grant burst-hold block
module tb_ah_gnt_burst_hold;
   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  req, gnt, gnt_busy;
   logic [15:0] req_len;
   logic        dn_valid, dn_ready, dn_last, upd_valid, upd_abort, gnt_err;
   logic [1:0]  dn_id, upd_id;
   logic [2:0]  bq[$];
   logic [2:0]  uq[$];
   int          vectors = 0;
   int          miscompares = 0;
   ah_gnt_burst_hold #(.N(4), .LW(4), .TMO(64)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .gnt       (gnt),
      .req_len   (req_len),
      .gnt_busy  (gnt_busy),
      .dn_valid  (dn_valid),
      .dn_ready  (dn_ready),
      .dn_id     (dn_id),
      .dn_last   (dn_last),
      .upd_valid (upd_valid),
      .upd_id    (upd_id),
      .upd_abort (upd_abort),
      .gnt_err   (gnt_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drain(input string tag);
      for (int i = 0; i < 100 && (bq.size() != 0 || uq.size() != 0); i++) tick();
      chk(tag, bq.size() + uq.size(), 0);
   endtask
   // scoreboard: every accepted beat and every update pulse must match the next expectation
   always @(negedge clk) begin
      logic [2:0] e;
      if (dn_valid && dn_ready) begin
         chk("beat_expected", bq.size() != 0, 1);
         if (bq.size() != 0) begin
            e = bq.pop_front();
            chk("beat", {dn_id, dn_last}, e);
         end
      end
      if (upd_valid) begin
         chk("upd_expected", uq.size() != 0, 1);
         if (uq.size() != 0) begin
            e = uq.pop_front();
            chk("upd", {upd_id, upd_abort}, e);
         end
      end
   end
   initial begin
      rstn = 1'b0; req = 4'hF; gnt = 4'h0; req_len = 16'h0; dn_ready = 1'b1;
      #12;
      chk("reset_outputs", {gnt_busy, dn_valid, dn_id, dn_last, upd_valid, upd_id, upd_abort, gnt_err}, 0);
      tick();
      rstn = 1'b1;
      tick();
      // four-beat burst for requester 2; a grant during the burst must be ignored
      req_len = 16'h0300;
      repeat (3) bq.push_back({2'd2, 1'b0});
      bq.push_back({2'd2, 1'b1});
      uq.push_back({2'd2, 1'b0});
      gnt = 4'b0100;
      tick();
      gnt = 4'b0001;
      chk("t1_busy", gnt_busy, 4'hF);
      chk("t1_valid", dn_valid, 1);
      tick();
      gnt = 4'b0000;
      drain("t1_drain");
      // single-beat burst: busy for exactly two cycles
      req_len = 16'h0000;
      bq.push_back({2'd0, 1'b1});
      uq.push_back({2'd0, 1'b0});
      gnt = 4'b0001;
      tick();
      gnt = 4'b0000;
      chk("t2_busy_c1", gnt_busy, 4'hF);
      tick();
      chk("t2_busy_c2", {gnt_busy, upd_valid}, {4'hF, 1'b1});
      tick();
      chk("t2_busy_c3", gnt_busy, 4'h0);
      drain("t2_drain");
      // multi-hot grant picks the lowest index and flags an error once
      req_len = 16'h0010;
      bq.push_back({2'd1, 1'b0});
      bq.push_back({2'd1, 1'b1});
      uq.push_back({2'd1, 1'b0});
      gnt = 4'b1010;
      tick();
      gnt = 4'b0000;
      chk("t3_err_pulse", gnt_err, 1);
      chk("t3_owner", dn_id, 1);
      tick();
      chk("t3_err_clear", gnt_err, 0);
      drain("t3_drain");
      // owner 3 drops its request after two accepted beats
      req_len = 16'h7000;
      repeat (2) bq.push_back({2'd3, 1'b0});
      uq.push_back({2'd3, 1'b1});
      gnt = 4'b1000;
      tick();
      gnt = 4'b0000;
      tick();
      tick();
      req = 4'b0111;
      dn_ready = 1'b0;
      tick();
      chk("t4_release", {upd_valid, upd_abort, upd_id, dn_valid}, {1'b1, 1'b1, 2'd3, 1'b0});
      tick();
      req = 4'hF;
      dn_ready = 1'b1;
      drain("t4_drain");
      // stall timeout after 64 stalled cycles
      req_len = 16'h0003;
      dn_ready = 1'b0;
      uq.push_back({2'd0, 1'b1});
      gnt = 4'b0001;
      tick();
      gnt = 4'b0000;
      repeat (63) tick();
      chk("t5_not_yet", {upd_valid, dn_valid}, {1'b0, 1'b1});
      tick();
      chk("t5_timeout", {upd_valid, upd_abort}, {1'b1, 1'b1});
      dn_ready = 1'b1;
      drain("t5_drain");
      // asynchronous reset mid-burst, then a grant on the first edge after release
      req_len = 16'h0007;
      repeat (2) bq.push_back({2'd0, 1'b0});
      gnt = 4'b0001;
      tick();
      gnt = 4'b0000;
      tick();
      tick();
      rstn = 1'b0;
      #1;
      chk("t6_async_reset", {gnt_busy, dn_valid, dn_id, dn_last, upd_valid, upd_id, upd_abort, gnt_err}, 0);
      chk("t6_queue", bq.size() + uq.size(), 0);
      tick();
      tick();
      req_len = 16'h0000;
      gnt = 4'b0001;
      bq.push_back({2'd0, 1'b1});
      uq.push_back({2'd0, 1'b0});
      rstn = 1'b1;
      tick();
      gnt = 4'b0000;
      chk("t7_first_edge", {dn_valid, dn_last}, {1'b1, 1'b1});
      drain("t7_drain");
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
